lc3b_fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined LC-3b; sits directly upstream of decode, which consumes its lc3b_word instruction and slices lc3b_opcode from bits [15:12].
- Owns the PC and issues word reads to the instruction port of the cache hierarchy, using a hold-until-response handshake.
- Presents a registered IF/ID latch to decode, holds it under downstream stall, and supports branch redirect.
- Handles a redirect that arrives while a memory read is still in flight.

---
 rtl/lc3b_types.sv | 24 ++
 rtl/lc3b_fetch_stage.sv | 187 ++++++++++++++++++
 tb/tb_lc3b_fetch_stage.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b type package.
// Provides the 16-bit machine word, the opcode field type that decode slices
// from instruction bits [15:12], the fetch-stage FSM state encoding and a
// helper for the sequential PC increment.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } lc3b_fetch_state;

  // Word addresses always have bit 0 clear.
  localparam lc3b_word WORD_ALIGN_MASK = 16'hFFFE;

  // Next sequential instruction address; 16-bit wrap (FFFE -> 0000) is intended.
  function automatic lc3b_word pc_plus2(input lc3b_word pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/lc3b_fetch_stage.sv
// LC-3b instruction-fetch stage.
// Owns the PC, issues word reads to the instruction memory port with a
// hold-until-response handshake, and presents a registered IF/ID latch.
// A one-entry skid buffer absorbs a response that arrives while decode is
// stalled. Redirects are honoured every cycle; a redirect that lands while a
// read is still outstanding moves to DRAIN, which keeps the old request
// stable until its response arrives and then discards it.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_address/read read request to memory (registered)
//   imem_rdata/resp   returned instruction and single-cycle completion strobe
//   redirect_valid/pc taken branch/jump/trap target from a later stage
//   id_stall          decode cannot accept; hold the IF/ID latch
//   if_valid/ir/pc/pc_plus2  registered IF/ID latch
module lc3b_fetch_stage
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic     clk,
  input  logic     rst_n,
  output lc3b_word imem_address,
  output logic     imem_read,
  input  lc3b_word imem_rdata,
  input  logic     imem_resp,
  input  logic     redirect_valid,
  input  lc3b_word redirect_pc,
  input  logic     id_stall,
  output logic     if_valid,
  output lc3b_word if_ir,
  output lc3b_word if_pc,
  output lc3b_word if_pc_plus2
);

  localparam lc3b_word RESET_PC_ALIGNED = RESET_PC & WORD_ALIGN_MASK;

  lc3b_fetch_state state_q, state_d;
  lc3b_word pc_q, pc_d;
  lc3b_word addr_q, addr_d;
  logic     read_q, read_d;
  logic     valid_q, valid_d;
  lc3b_word ir_q, ir_d;
  lc3b_word ifpc_q, ifpc_d;
  lc3b_word ifpc2_q, ifpc2_d;
  logic     skid_valid_q, skid_valid_d;
  lc3b_word skid_ir_q, skid_ir_d;
  lc3b_word skid_pc_q, skid_pc_d;

  // Next-state, PC, skid buffer and IF/ID latch update.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    ir_d         = ir_q;
    ifpc_d       = ifpc_q;
    ifpc2_d      = ifpc2_q;
    skid_valid_d = skid_valid_q;
    skid_ir_d    = skid_ir_q;
    skid_pc_d    = skid_pc_q;

    if (redirect_valid) begin
      pc_d         = redirect_pc & WORD_ALIGN_MASK;
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
      case (state_q)
        FETCH: begin
          // A response in the same cycle retires the old read; otherwise it
          // is still in flight and must be drained.
          if (imem_resp) begin
            state_d = FETCH;
          end else begin
            state_d = DRAIN;
          end
        end
        HOLD: begin
          state_d = FETCH;
        end
        DRAIN: begin
          // The outstanding read completing this cycle ends the drain even
          // though a newer target arrived; waiting longer would deadlock.
          if (imem_resp) begin
            state_d = FETCH;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_resp) begin
            if (!valid_q || !id_stall) begin
              valid_d = 1'b1;
              ir_d    = imem_rdata;
              ifpc_d  = pc_q;
              ifpc2_d = pc_plus2(pc_q);
              pc_d    = pc_plus2(pc_q);
            end else begin
              skid_valid_d = 1'b1;
              skid_ir_d    = imem_rdata;
              skid_pc_d    = pc_q;
              state_d      = HOLD;
            end
          end else if (!id_stall) begin
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end
        HOLD: begin
          if (!id_stall) begin
            valid_d      = skid_valid_q;
            ir_d         = skid_ir_q;
            ifpc_d       = skid_pc_q;
            ifpc2_d      = pc_plus2(skid_pc_q);
            pc_d         = pc_plus2(pc_q);
            skid_valid_d = 1'b0;
            state_d      = FETCH;
          end else begin
            state_d = HOLD;
          end
        end
        DRAIN: begin
          if (imem_resp) begin
            state_d = FETCH;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d      = FETCH;
          valid_d      = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end

    // Request outputs are registered: DRAIN freezes the in-flight address.
    read_d = (state_d != HOLD);
    if (state_d == DRAIN) begin
      addr_d = addr_q;
    end else begin
      addr_d = pc_d;
    end
  end

  // State, request and latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC_ALIGNED;
      addr_q       <= RESET_PC_ALIGNED;
      read_q       <= 1'b0;
      valid_q      <= 1'b0;
      ir_q         <= 16'h0000;
      ifpc_q       <= 16'h0000;
      ifpc2_q      <= 16'h0000;
      skid_valid_q <= 1'b0;
      skid_ir_q    <= 16'h0000;
      skid_pc_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      read_q       <= read_d;
      valid_q      <= valid_d;
      ir_q         <= ir_d;
      ifpc_q       <= ifpc_d;
      ifpc2_q      <= ifpc2_d;
      skid_valid_q <= skid_valid_d;
      skid_ir_q    <= skid_ir_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign imem_address = addr_q;
  assign imem_read    = read_q;
  assign if_valid     = valid_q;
  assign if_ir        = ir_q;
  assign if_pc        = ifpc_q;
  assign if_pc_plus2  = ifpc2_q;

endmodule

// File: tb/tb_lc3b_fetch_stage.sv
// Testbench for lc3b_fetch_stage: a directed vector table walking the main
// fetch, stall, redirect, drain and wrap scenarios, a hand-written reset
// during HOLD, then randomized traffic against a transaction-level model.
module tb_lc3b_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_address;
  logic        imem_read;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [15:0] if_ir;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;

  int total;
  int bad;

  lc3b_fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_address   (imem_address),
    .imem_read      (imem_read),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .if_valid       (if_valid),
    .if_ir          (if_ir),
    .if_pc          (if_pc),
    .if_pc_plus2    (if_pc_plus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        resp;
    logic [15:0] rdata;
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        e_read;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_ir;
    logic [15:0] e_pc;
    logic [15:0] e_pc2;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic resp, input logic [15:0] rdata,
                              input logic stall, input logic redir,
                              input logic [15:0] rpc, input logic e_read,
                              input logic [15:0] e_addr, input logic e_valid,
                              input logic [15:0] e_ir, input logic [15:0] e_pc,
                              input logic [15:0] e_pc2);
    vec_t v;
    v.resp = resp; v.rdata = rdata; v.stall = stall; v.redir = redir; v.rpc = rpc;
    v.e_read = e_read; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_ir = e_ir; v.e_pc = e_pc; v.e_pc2 = e_pc2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_read, input logic [15:0] e_addr,
                         input logic e_valid, input logic [15:0] e_ir,
                         input logic [15:0] e_pc, input logic [15:0] e_pc2);
    chk({tag, ".imem_read"}, {15'd0, imem_read}, {15'd0, e_read});
    chk({tag, ".imem_address"}, imem_address, e_addr);
    chk({tag, ".if_valid"}, {15'd0, if_valid}, {15'd0, e_valid});
    chk({tag, ".if_ir"}, if_ir, e_ir);
    chk({tag, ".if_pc"}, if_pc, e_pc);
    chk({tag, ".if_pc_plus2"}, if_pc_plus2, e_pc2);
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [15:0] m_pc, m_addr, m_ir, m_ipc, m_ipc2, m_sk_ir, m_sk_pc;
  bit          m_read, m_valid, m_parked, m_discard;

  task automatic model_reset();
    m_pc = 16'h0000; m_addr = 16'h0000; m_read = 1'b0;
    m_valid = 1'b0; m_ir = 16'h0000; m_ipc = 16'h0000; m_ipc2 = 16'h0000;
    m_parked = 1'b0; m_discard = 1'b0; m_sk_ir = 16'h0000; m_sk_pc = 16'h0000;
  endtask

  task automatic model_step(input bit resp, input logic [15:0] rdata, input bit stall,
                            input bit redir, input logic [15:0] rpc);
    bit was_parked;
    was_parked = m_parked;
    if (redir) begin
      m_valid  = 1'b0;
      m_parked = 1'b0;
      // A read left unanswered at redirect time has to be waited out.
      m_discard = was_parked ? 1'b0 : !resp;
      m_pc = rpc & 16'hFFFE;
    end else if (m_discard) begin
      if (resp) m_discard = 1'b0;
    end else if (m_parked) begin
      if (!stall) begin
        m_valid = 1'b1; m_ir = m_sk_ir; m_ipc = m_sk_pc; m_ipc2 = m_sk_pc + 16'd2;
        m_pc = m_pc + 16'd2; m_parked = 1'b0;
      end
    end else if (resp) begin
      if (!m_valid || !stall) begin
        m_valid = 1'b1; m_ir = rdata; m_ipc = m_pc; m_ipc2 = m_pc + 16'd2;
        m_pc = m_pc + 16'd2;
      end else begin
        m_sk_ir = rdata; m_sk_pc = m_pc; m_parked = 1'b1;
      end
    end else if (!stall) begin
      m_valid = 1'b0;
    end
    m_read = !m_parked;
    if (!m_discard) m_addr = m_pc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    bit busy;
    bit do_rst;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    imem_rdata = 16'h0000; imem_resp = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0000; id_stall = 1'b0;

    vecs[0]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    vecs[1]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    vecs[2]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    vecs[3]  = mk(1'b1, 16'h1021, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h1021, 16'h0000, 16'h0002);
    vecs[4]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h1021, 16'h0000, 16'h0002);
    vecs[5]  = mk(1'b1, 16'h1262, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h1262, 16'h0002, 16'h0004);
    vecs[6]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h1262, 16'h0002, 16'h0004);
    vecs[7]  = mk(1'b1, 16'h5020, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h1262, 16'h0002, 16'h0004);
    vecs[8]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h1262, 16'h0002, 16'h0004);
    vecs[9]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h5020, 16'h0004, 16'h0006);
    vecs[10] = mk(1'b1, 16'h1DA1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 16'h1DA1, 16'h0006, 16'h0008);
    vecs[11] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h2000, 1'b1, 16'h0008, 1'b0, 16'h1DA1, 16'h0006, 16'h0008);
    vecs[12] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h3001, 1'b1, 16'h0008, 1'b0, 16'h1DA1, 16'h0006, 16'h0008);
    vecs[13] = mk(1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h3000, 1'b0, 16'h1DA1, 16'h0006, 16'h0008);
    vecs[14] = mk(1'b1, 16'h1402, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h3002, 1'b1, 16'h1402, 16'h3000, 16'h3002);
    vecs[15] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h000A, 1'b1, 16'h3002, 1'b0, 16'h1402, 16'h3000, 16'h3002);
    vecs[16] = mk(1'b1, 16'h0BAD, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h000A, 1'b0, 16'h1402, 16'h3000, 16'h3002);
    vecs[17] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h000A, 1'b0, 16'h1402, 16'h3000, 16'h3002);
    vecs[18] = mk(1'b1, 16'hABCD, 1'b0, 1'b1, 16'h0100, 1'b1, 16'h0100, 1'b0, 16'h1402, 16'h3000, 16'h3002);
    vecs[19] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0100, 1'b0, 16'h1402, 16'h3000, 16'h3002);
    vecs[20] = mk(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 16'h1402, 16'h3000, 16'h3002);
    vecs[21] = mk(1'b1, 16'hC1C0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'hC1C0, 16'hFFFE, 16'h0000);
    vecs[22] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'hC1C0, 16'hFFFE, 16'h0000);
    vecs[23] = mk(1'b1, 16'h2222, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hC1C0, 16'hFFFE, 16'h0000);
    vecs[24] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0200, 1'b1, 16'h0200, 1'b0, 16'hC1C0, 16'hFFFE, 16'h0000);
    vecs[25] = mk(1'b1, 16'h3333, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0202, 1'b1, 16'h3333, 16'h0200, 16'h0202);
    vecs[26] = mk(1'b1, 16'h4444, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0202, 1'b1, 16'h3333, 16'h0200, 16'h0202);
    vecs[27] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0202, 1'b1, 16'h3333, 16'h0200, 16'h0202);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    rst_n = 1'b1;

    // Directed table: inputs applied before an edge, outputs checked after it.
    for (int i = 0; i < NVEC; i++) begin
      imem_resp = vecs[i].resp; imem_rdata = vecs[i].rdata; id_stall = vecs[i].stall;
      redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_read, vecs[i].e_addr, vecs[i].e_valid,
              vecs[i].e_ir, vecs[i].e_pc, vecs[i].e_pc2);
    end

    // Asynchronous reset while parked in HOLD with decode stalled.
    imem_resp = 1'b0; redirect_valid = 1'b0; id_stall = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_all("rst_hold_now", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    chk_all("rst_hold_edge", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    rst_n = 1'b1; id_stall = 1'b0;
    @(posedge clk);
    #1;
    chk_all("rst_release", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000);

    // Randomized traffic against the model.
    rst_n = 1'b0;
    model_reset();
    busy = 1'b0; lat = 0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4000; c++) begin
      do_rst = ($urandom_range(0, 299) == 0);
      imem_rdata     = 16'($urandom);
      id_stall       = ($urandom_range(0, 9) < 4);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 16'($urandom);
      if (do_rst) begin
        rst_n = 1'b0; imem_resp = 1'b0; busy = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
        if (imem_read) begin
          if (!busy) begin
            busy = 1'b1;
            lat  = $urandom_range(1, 3);
          end
          if (lat == 0) begin
            imem_resp = 1'b1; busy = 1'b0;
          end else begin
            imem_resp = 1'b0; lat--;
          end
        end else begin
          imem_resp = 1'b0; busy = 1'b0;
        end
        model_step(imem_resp, imem_rdata, id_stall, redirect_valid, redirect_pc);
      end
      @(posedge clk);
      #1;
      chk_all($sformatf("rnd%0d", c), m_read, m_addr, m_valid, m_ir, m_ipc, m_ipc2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
